// File: rtl/qdec_pkg.sv
// Shared types and constants for the qdec bitstream front end.
package qdec_pkg;

  localparam logic [7:0] QDEC_EPB_BYTE = 8'h03;

  typedef enum logic [1:0] {
    BSF_IDLE,
    BSF_RUN,
    BSF_DRAIN
  } bsf_state_t;

  typedef logic [31:0] bs_word_t;

endpackage

// File: rtl/qdec_bs_fetch_if.sv
// Bitstream RAM read port and CABAC byte stream of qdec_bs_fetch.
interface qdec_bs_fetch_if #(
  parameter int ADDR_W = 16
);
  import qdec_pkg::*;

  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  bs_word_t          mem_rdata;
  logic [7:0]        bitstreamFetch;
  logic              bitstreamFetch_vld;
  logic              bitstreamFetch_rdy;

  modport master (
    output mem_re, mem_addr, bitstreamFetch, bitstreamFetch_vld,
    input  mem_rdata, bitstreamFetch_rdy
  );

  modport slave (
    input  mem_re, mem_addr, bitstreamFetch, bitstreamFetch_vld,
    output mem_rdata, bitstreamFetch_rdy
  );

endinterface

// File: rtl/qdec_bs_word_fifo.sv
// Synchronous DEPTH x 32 word FIFO with asynchronous active-high reset.
module qdec_bs_word_fifo
  import qdec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  bs_word_t                     wdata,
  input  logic                         pop,
  output bs_word_t                     rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  bs_word_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/qdec_bs_fetch.sv
// Payload prefetch, big-endian byte unpack and emulation-prevention removal for CABAC.
// Optional epb_cnt port/counter is enabled by defining QDEC_BS_EPB_CNT_EN.
module qdec_bs_fetch
  import qdec_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W+1:0]   byte_len,
  qdec_bs_fetch_if.master     bs,
  output logic                busy,
  output logic                done
`ifdef QDEC_BS_EPB_CNT_EN
  ,
  output logic [ADDR_W+1:0]   epb_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  bsf_state_t         state;
  bsf_state_t         state_nxt;
  logic               done_set;

  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W+1:0]  len_q;
  logic [ADDR_W+1:0]  consumed;
  logic [ADDR_W:0]    words_issued;
  logic [ADDR_W:0]    words_needed;
  logic               rd_pending;
  logic [1:0]         byte_idx;
  logic [1:0]         zero_cnt;
  logic [7:0]         out_byte;
  logic               out_vld;
  logic               done_q;

  logic               fifo_push;
  logic               fifo_pop;
  bs_word_t           fifo_rdata;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;

  logic               start_ok;
  logic               bypass;
  bs_word_t           cur_word;
  logic               src_vld;
  logic               out_free;
  logic               take;
  logic [7:0]         raw_byte;
  logic               last_byte;
  logic               word_done;
  logic               drop;
  logic               issue;

  qdec_bs_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (bs.mem_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // With an empty FIFO the returning word is unpacked straight off the bus for 2-cycle latency
  assign start_ok     = (state == BSF_IDLE) && start;
  assign bypass       = fifo_empty && rd_pending;
  assign cur_word     = bypass ? bs.mem_rdata : fifo_rdata;
  assign src_vld      = (state == BSF_RUN) && (!fifo_empty || rd_pending);
  assign out_free     = !out_vld || bs.bitstreamFetch_rdy;
  assign take         = src_vld && out_free;
  assign last_byte    = (consumed + (ADDR_W+2)'(1)) == len_q;
  assign word_done    = (byte_idx == 2'd3) || last_byte;
  assign drop         = (raw_byte == QDEC_EPB_BYTE) && (zero_cnt == 2'd2);
  assign words_needed = {1'b0, len_q[ADDR_W+1:2]} + (ADDR_W+1)'(|len_q[1:0]);
  assign issue        = (state == BSF_RUN)
                     && (({1'b0, fifo_count} + {{CW{1'b0}}, rd_pending}) < (CW+1)'(FIFO_DEPTH))
                     && (words_issued < words_needed);
  assign fifo_push    = rd_pending && !(bypass && take && word_done);
  assign fifo_pop     = take && word_done && !bypass;

  always_comb begin
    raw_byte = cur_word[31:24];
    case (byte_idx)
      2'd1:    raw_byte = cur_word[23:16];
      2'd2:    raw_byte = cur_word[15:8];
      2'd3:    raw_byte = cur_word[7:0];
      default: raw_byte = cur_word[31:24];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BSF_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      BSF_IDLE: begin
        if (start) begin
          if (byte_len != '0) state_nxt = BSF_RUN;
          else                done_set  = 1'b1;
        end
      end
      BSF_RUN: begin
        if (take && last_byte) state_nxt = BSF_DRAIN;
      end
      BSF_DRAIN: begin
        if (out_free) begin
          state_nxt = BSF_IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = BSF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q       <= '0;
      len_q        <= '0;
      consumed     <= '0;
      words_issued <= '0;
      rd_pending   <= 1'b0;
      byte_idx     <= '0;
      zero_cnt     <= '0;
      out_byte     <= '0;
      out_vld      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rd_pending <= issue;
      done_q     <= done_set;
      if (start_ok) begin
        base_q       <= base_addr;
        len_q        <= byte_len;
        consumed     <= '0;
        words_issued <= '0;
        byte_idx     <= '0;
        zero_cnt     <= '0;
      end else begin
        if (issue) words_issued <= words_issued + (ADDR_W+1)'(1);
        if (take) begin
          consumed <= consumed + (ADDR_W+2)'(1);
          byte_idx <= word_done ? 2'd0 : byte_idx + 2'd1;
          if (drop)                  zero_cnt <= 2'd0;
          else if (raw_byte != 8'h00) zero_cnt <= 2'd0;
          else if (zero_cnt != 2'd2)  zero_cnt <= zero_cnt + 2'd1;
        end
      end
      // Output register reloads in the same cycle it is accepted; held otherwise
      if (take && !drop) begin
        out_byte <= raw_byte;
        out_vld  <= 1'b1;
      end else if (bs.bitstreamFetch_rdy) begin
        out_vld  <= 1'b0;
      end
    end
  end

`ifdef QDEC_BS_EPB_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               epb_cnt <= '0;
    else if (start_ok)                     epb_cnt <= '0;
    else if (take && drop && epb_cnt != '1) epb_cnt <= epb_cnt + (ADDR_W+2)'(1);
  end
`endif

  assign bs.mem_re             = issue;
  assign bs.mem_addr           = base_q + words_issued[ADDR_W-1:0];
  assign bs.bitstreamFetch     = out_byte;
  assign bs.bitstreamFetch_vld = out_vld;
  assign busy                  = (state != BSF_IDLE);
  assign done                  = done_q;

endmodule

// File: tb/tb_qdec_bs_fetch.sv
// Self-checking bench for qdec_bs_fetch: table-driven payloads with a byte scoreboard,
// plus hand sequences for mid-payload reset and empty payloads.
module tb_qdec_bs_fetch;
  import qdec_pkg::*;

  localparam int ADDR_W = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W+1:0] byte_len;
  logic              busy;
  logic              done;
`ifdef QDEC_BS_EPB_CNT_EN
  logic [ADDR_W+1:0] epb_cnt;
`endif

  qdec_bs_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  qdec_bs_fetch #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .byte_len  (byte_len),
    .bs        (bus),
    .busy      (busy),
    .done      (done)
`ifdef QDEC_BS_EPB_CNT_EN
    ,
    .epb_cnt   (epb_cnt)
`endif
  );

  typedef struct {
    logic [15:0]  base;
    logic [17:0]  len;
    logic [127:0] words;
    logic [95:0]  exp_bytes;
    int           exp_n;
    int           exp_epb;
    int           rdy_mode;
    bit           poke;
  } vec_t;

  vec_t        vecs[6];
  bs_word_t    mem[256];
  logic [7:0]  exp_q[$];
  int          n_cmp;
  int          n_fail;
  int          cyc;
  int          rd_cnt;
  int          done_cnt;
  int          vld_cnt;
  int          first_re;
  int          first_vld;
  int          rdy_mode;
  logic [15:0] cur_base;
  bit          stalled;
  logic [7:0]  held;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: data valid exactly one cycle after mem_re, garbage otherwise
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_re ? mem[bus.mem_addr[7:0]] : 32'hDEADBEEF;
  end

  function automatic vec_t mk(input logic [15:0] b, input logic [17:0] l, input logic [127:0] w,
                              input logic [95:0] e, input int n, input int epb, input int mode,
                              input bit poke);
    vec_t v;
    v.base = b; v.len = l; v.words = w; v.exp_bytes = e;
    v.exp_n = n; v.exp_epb = epb; v.rdy_mode = mode; v.poke = poke;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample outputs on the falling edge, then advance to just after the next rising edge
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("stall_vld", 32'(bus.bitstreamFetch_vld), 32'd1);
        checkOutput("stall_hold", 32'(bus.bitstreamFetch), 32'(held));
      end
      if (bus.bitstreamFetch_vld && bus.bitstreamFetch_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL extra_byte: got 0x%0h expected no byte (cycle %0d)", bus.bitstreamFetch, cyc);
        end else begin
          checkOutput("byte", 32'(bus.bitstreamFetch), 32'(exp_q.pop_front()));
        end
      end
      stalled = bus.bitstreamFetch_vld && !bus.bitstreamFetch_rdy;
      held    = bus.bitstreamFetch;
      if (bus.mem_re) begin
        checkOutput("mem_addr", 32'(bus.mem_addr), 32'(16'(cur_base + 16'(rd_cnt))));
        rd_cnt++;
        if (first_re < 0) first_re = cyc;
      end
      if (bus.bitstreamFetch_vld) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (done) done_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      1:       bus.bitstreamFetch_rdy = cyc[0];
      2:       bus.bitstreamFetch_rdy = (cyc % 5) < 2;
      3:       bus.bitstreamFetch_rdy = 1'b0;
      default: bus.bitstreamFetch_rdy = 1'b1;
    endcase
  endtask

  task automatic clearCounters(input logic [15:0] b, input int mode);
    cur_base  = b;
    rd_cnt    = 0;
    done_cnt  = 0;
    vld_cnt   = 0;
    first_re  = -1;
    first_vld = -1;
    rdy_mode  = mode;
  endtask

  task automatic applyStimulus(input vec_t v);
    int reads;
    reads = (int'(v.len) + 3) / 4;
    for (int i = 0; i < reads; i++) mem[8'(v.base + 16'(i))] = v.words[127-32*i -: 32];
    for (int i = 0; i < v.exp_n; i++) exp_q.push_back(v.exp_bytes[95-8*i -: 8]);
    clearCounters(v.base, v.rdy_mode);
    start     = 1'b1;
    base_addr = v.base;
    byte_len  = v.len;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
`ifdef QDEC_BS_EPB_CNT_EN
    checkOutput("epb_clear", 32'(epb_cnt), 32'd0);
`endif
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      if (v.poke && c == 3) begin
        start     = 1'b1;
        base_addr = 16'h0060;
        byte_len  = 18'd4;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    repeat (4) tick();
    checkOutput("done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("read_count", 32'(rd_cnt), 32'(reads));
    checkOutput("bytes_left", 32'(exp_q.size()), 32'd0);
    checkOutput("latency", 32'(first_vld - first_re), 32'd2);
    checkOutput("busy_end", 32'(busy), 32'd0);
`ifdef QDEC_BS_EPB_CNT_EN
    checkOutput("epb_cnt", 32'(epb_cnt), 32'(v.exp_epb));
`endif
    exp_q.delete();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; stalled = 1'b0; held = '0;
    rst = 1'b1; start = 1'b0; base_addr = '0; byte_len = '0;
    bus.bitstreamFetch_rdy = 1'b0;
    clearCounters(16'h0, 0);
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5A5A5;

    vecs[0] = mk(16'h0010, 18'd4, {32'h00000301, 96'h0},
                 {8'h00, 8'h00, 8'h01, 72'h0}, 3, 1, 0, 1'b0);
    vecs[1] = mk(16'h0020, 18'd4, {32'h00000303, 96'h0},
                 {8'h00, 8'h00, 8'h03, 72'h0}, 3, 1, 0, 1'b0);
    vecs[2] = mk(16'h0030, 18'd7, {32'h11223344, 32'h556677AA, 64'h0},
                 {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 40'h0}, 7, 0, 1, 1'b0);
    vecs[3] = mk(16'h0040, 18'd8, {32'hABCD0000, 32'h03040506, 64'h0},
                 {8'hAB, 8'hCD, 8'h00, 8'h00, 8'h04, 8'h05, 8'h06, 40'h0}, 7, 1, 0, 1'b1);
    vecs[4] = mk(16'h0050, 18'd1, {32'h03FFFFFF, 96'h0},
                 {8'h03, 88'h0}, 1, 0, 0, 1'b0);
    vecs[5] = mk(16'hFFFE, 18'd13, {32'h00000003, 32'h00030000, 32'h03AA0000, 32'h03FFFFFF},
                 {8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 16'h0},
                 10, 3, 2, 1'b0);

    #2;
    checkOutput("rst_mem_re", 32'(bus.mem_re), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_vld", 32'(bus.bitstreamFetch_vld), 32'd0);
    checkOutput("rst_byte", 32'(bus.bitstreamFetch), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
`ifdef QDEC_BS_EPB_CNT_EN
    checkOutput("rst_epb_cnt", 32'(epb_cnt), 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    $display("[TB] reset during a stalled payload");
    for (int i = 0; i < 4; i++) mem[8'h80 + i] = 32'h10203040 + 32'(i);
    clearCounters(16'h0080, 3);
    bus.bitstreamFetch_rdy = 1'b0;
    start = 1'b1; base_addr = 16'h0080; byte_len = 18'd16;
    tick();
    start = 1'b0;
    repeat (6) tick();
    checkOutput("pre_rst_vld", 32'(bus.bitstreamFetch_vld), 32'd1);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_vld", 32'(bus.bitstreamFetch_vld), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_mem_re", 32'(bus.mem_re), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    rdy_mode = 0;
    exp_q.delete();
    tick();
    applyStimulus(vecs[0]);

    $display("[TB] empty payload");
    clearCounters(16'h0010, 0);
    start = 1'b1; base_addr = 16'h0010; byte_len = 18'd0;
    tick();
    start = 1'b0;
    checkOutput("len0_done", 32'(done), 32'd1);
    tick();
    checkOutput("len0_done_drop", 32'(done), 32'd0);
    repeat (4) tick();
    checkOutput("len0_reads", 32'(rd_cnt), 32'd0);
    checkOutput("len0_vld", 32'(vld_cnt), 32'd0);
    checkOutput("len0_done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("len0_busy", 32'(busy), 32'd0);

    applyStimulus(vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
